// File: rtl/pwm_ctrl_pkg.sv
// Shared types and default constants for the pwm
// bank and its fade sequencer.
package pwm_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RAMP,
    S_DONE
  } fade_state_t;

  localparam int DEF_N        = 8;
  localparam int DEF_CHANNELS = 3;
  localparam int DEF_PRESCALE = 1000;
  localparam int DEF_RW       = 8;

endpackage

// File: rtl/pwm_tick_gen.sv
// Shared pwm step strobe and once-per-pwm-cycle
// period tick, both registered.
module pwm_tick_gen #(
  parameter int PRESCALE = 1000,
  parameter int N        = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic pwm_step,
  output logic period_tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [N-1:0]  pcnt_q, pcnt_d;
  logic          step_q, step_d;
  logic          tick_q, tick_d;

  // next prescaler, period counter and strobes
  always_comb begin
    presc_d = '0;
    pcnt_d  = '0;
    step_d  = 1'b0;
    tick_d  = 1'b0;
    if (run) begin
      presc_d = (presc_q == PMAX) ? '0 : presc_q + 1'b1;
      pcnt_d  = step_q ? pcnt_q + 1'b1 : pcnt_q;
      step_d  = (presc_d == PMAX);
      tick_d  = step_d & (&pcnt_d);
    end
  end

  // state and strobe registers
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      pcnt_q  <= '0;
      step_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      pcnt_q  <= pcnt_d;
      step_q  <= step_d;
      tick_q  <= tick_d;
    end
  end

  assign pwm_step    = step_q;
  assign period_tick = tick_q;

endmodule

// File: rtl/pwm_fade_ctrl.sv
// Fade sequencer: owns the channel duty registers
// and ramps one channel per command.
module pwm_fade_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int PRESCALE = DEF_PRESCALE,
  parameter int RW       = DEF_RW,
  parameter int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [CW-1:0]         cmd_channel,
  input  logic [N-1:0]          cmd_target,
  input  logic [RW-1:0]         cmd_rate,
  output logic                  pwm_step,
  output logic [CHANNELS*N-1:0] duty,
  output logic                  busy,
  output logic                  done,
  output logic                  cmd_err
);

  fade_state_t   state_q, state_d;
  logic [CW-1:0] ch_q, ch_d;
  logic [N-1:0]  tgt_q, tgt_d;
  logic [RW-1:0] rate_q, rate_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          err_q, err_d;
  logic [N-1:0]  duty_q [CHANNELS];
  logic [N-1:0]  duty_d [CHANNELS];
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          cerr_q, cerr_d;
  logic [N-1:0]  cur;
  logic [N-1:0]  cmd_cur;
  logic          period_tick;
  logic          adv;

  pwm_tick_gen #(
    .PRESCALE (PRESCALE),
    .N        (N)
  ) u_tick (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .pwm_step    (pwm_step),
    .period_tick (period_tick)
  );

  assign adv = period_tick & run;

  // current duty of the latched and offered channels
  always_comb begin
    cur     = '0;
    cmd_cur = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (ch_q == CW'(i))        cur     = duty_q[i];
      if (cmd_channel == CW'(i)) cmd_cur = duty_q[i];
    end
  end

  // command FSM and duty register updates
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    tgt_d   = tgt_q;
    rate_d  = rate_q;
    rcnt_d  = rcnt_q;
    err_d   = err_q;
    duty_d  = duty_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          ch_d   = cmd_channel;
          tgt_d  = cmd_target;
          rate_d = cmd_rate;
          rcnt_d = '0;
          err_d  = 1'b0;
          if (int'(cmd_channel) >= CHANNELS) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else if (cmd_rate == '0 ||
                       cmd_cur == cmd_target) begin
            for (int i = 0; i < CHANNELS; i++)
              if (cmd_channel == CW'(i))
                duty_d[i] = cmd_target;
            state_d = S_DONE;
          end else begin
            state_d = S_RAMP;
          end
        end
      end
      S_RAMP: begin
        if (cur == tgt_q) begin
          state_d = S_DONE;
        end else if (adv) begin
          if (rcnt_q == rate_q - 1'b1) begin
            rcnt_d = '0;
            for (int i = 0; i < CHANNELS; i++)
              if (ch_q == CW'(i))
                duty_d[i] = (cur < tgt_q) ? cur + 1'b1
                                          : cur - 1'b1;
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    cerr_d = done_d & err_d;
  end

  // FSM, command and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      tgt_q   <= '0;
      rate_q  <= '0;
      rcnt_q  <= '0;
      err_q   <= 1'b0;
      duty_q  <= '{default: '0};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      tgt_q   <= tgt_d;
      rate_q  <= rate_d;
      rcnt_q  <= rcnt_d;
      err_q   <= err_d;
      duty_q  <= duty_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cerr_q  <= cerr_d;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_duty
    assign duty[g*N +: N] = duty_q[g];
  end

  assign cmd_ready = (state_q == S_IDLE) & ~rst;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cmd_err   = cerr_q;

endmodule
